// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell reused over WIDTH cycles, LSB first.
// Result and carry-out are published only when the final bit has been summed.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, s_q, sum_q;
   logic             c_q, cout_q;
   logic [CW-1:0]    cnt_q;
   logic             cell_s, cell_co;
   logic             load, last;

   full_adder u_cell (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (c_q),
      .s  (cell_s),
      .co (cell_co)
   );

   // A start is only honoured outside RUN; RUN never restarts or queues.
   assign load = start && (state_q != StRun);
   assign last = (state_q == StRun) && (cnt_q == LastCnt);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last) state_d = StDone;
         StDone:  state_d = start ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= 1'b0;
         s_q    <= '0;
         cnt_q  <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (load) begin
         a_q   <= A;
         b_q   <= B;
         c_q   <= Cin;
         cnt_q <= '0;
      end else if (state_q == StRun) begin
         a_q <= a_q >> 1;
         b_q <= b_q >> 1;
         c_q <= cell_co;
         s_q <= {cell_s, s_q[WIDTH-1:1]};
         if (last) begin
            // Publish the completed word; cnt is cleared rather than wrapped.
            sum_q  <= {cell_s, s_q[WIDTH-1:1]};
            cout_q <= cell_co;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign S    = sum_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): vector table plus hand-written
// sequences for ignored restart, mid-run reset and back-to-back starts.

module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Cin = 1'b0;
   logic         busy, done, Cout;
   logic [W-1:0] S;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] prev_s  = '0;
   logic         prev_co = 1'b0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
   } vec_t;

   vec_t vecs [7];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .Cout  (Cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (busy && done) begin
            bad++;
            $display("FAIL busy_done_overlap: got busy=1 done=1 want not both at %0t", $time);
         end
      end
   end

   // Called just after a rising edge; that cycle is cycle 0 of the operation.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] es, input logic ec);
      A = a; B = b; Cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; A = ~a; B = ~b; Cin = ~ci;
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         chk("run_busy", busy, 1);
         chk("run_hold_s", S, prev_s);
         chk("run_hold_cout", Cout, prev_co);
      end
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("sum", S, es);
      chk("cout", Cout, ec);
      prev_s = es; prev_co = ec;
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, s: 8'h8D, co: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0};
      vecs[4] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, s: 8'hFF, co: 1'b0};
      vecs[5] = '{a: 8'h7F, b: 8'h01, cin: 1'b1, s: 8'h81, co: 1'b0};
      vecs[6] = '{a: 8'h80, b: 8'h80, cin: 1'b1, s: 8'h01, co: 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_s", S, 0);
      chk("rst_cout", Cout, 0);
      @(posedge clk); #1;

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);

      // Start during RUN is ignored
      A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      A = 8'hFF; B = 8'hFF; start = 1'b1;              // cycle 4
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(negedge clk);                       // cycles 5..9
      chk("ign_done", done, 1);
      chk("ign_sum", S, 8'h30);
      chk("ign_cout", Cout, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ign_no_restart", busy, 0);
      @(posedge clk); #1;

      // Reset mid-RUN aborts the operation
      A = 8'hAA; B = 8'h55; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;                                      // cycle 5
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_s", S, 0);
      chk("abort_cout", Cout, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      prev_s = '0; prev_co = 1'b0;
      @(posedge clk); #1;

      // Start held high: back-to-back operations
      A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      A = 8'h80; B = 8'h80;
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         chk("b2b_busy1", busy, 1);
         chk("b2b_hold0", S, 8'h00);
      end
      @(negedge clk);                                  // cycle 9
      chk("b2b_done1", done, 1);
      chk("b2b_sum1", S, 8'h02);
      chk("b2b_cout1", Cout, 0);
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         chk("b2b_busy2", busy, 1);
         chk("b2b_hold1", S, 8'h02);
      end
      @(negedge clk);                                  // cycle 18
      chk("b2b_done2", done, 1);
      chk("b2b_sum2", S, 8'h00);
      chk("b2b_cout2", Cout, 1);
      start = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
